uart_show_tx: RTL
=================

# uart_show_tx

Serial transmitter that drains the CPU top level's 16-byte display string (`tx_show`, `show_len`) onto a UART TX pin. On a `start` strobe it latches the string and length. It then sends each byte as an 8N1 frame at a fixed baud divisor and pulses `done` when the last stop bit completes. It sits directly downstream of the CPU/memory top and feeds the board's UART pin.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `tx_show`  in  128: string. Byte k is `tx_show[127-8k -: 8]`, so byte 0 is the MSB byte and is sent first.
- `show_len`  in  5: number of bytes to send. Values > 16 are clamped to 16.
- `start`  in  1: request transmission. Sampled only in IDLE.
- `busy`  out  1: high from the cycle after acceptance until the transfer finishes.
- `done`  out  1: one-cycle pulse at the end of a transfer.
- `tx`  out  1: UART line, registered, idle high.

## Operation
- States: IDLE, START, DATA, STOP, NEXT.
- **IDLE**
  - On `start`=1: latch `tx_show` into a 128-bit shift buffer and latch clamp(`show_len`) into a 5-bit remaining count.
  - If the count is 0, go to NEXT. Otherwise go to START.
  - `start` in any other state is ignored. Inputs are not re-sampled during a transfer.
- **START**: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
- **DATA**: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. A 3-bit bit index counts 0..7.
- **STOP**: `tx`=1 for CLKS_PER_BIT cycles, then NEXT.
- **NEXT** (one cycle, `tx`=1)
  - Decrement the remaining count and shift the buffer left by 8.
  - If bytes remain, go to START. Otherwise assert `done` and go to IDLE.
  - With `UART_SHOW_CRLF_EN` defined, the trailer bytes are inserted before `done` (see Configuration).
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state transition.
- Reset values: state IDLE, `tx`=1, `busy`=0, `done`=0, counters 0, buffer 0.
- Reset asserted mid-frame: `tx`=1 and `busy`=0 from the next edge. No `done` pulse. The partial frame is abandoned.

## Timing
- Acceptance edge is T0.
- `busy`=1 and `tx`=0 (start bit) are visible after edge T0+1. `tx` is registered, so the line change is one cycle after the state change.
- Each byte occupies 10·CLKS_PER_BIT + 1 cycles, including the NEXT cycle.
- For N > 0 bytes, `done` is high in cycle T0 + N·(10·CLKS_PER_BIT+1) + 1.
  - `busy` falls in that same cycle.
  - A new `start` is accepted the cycle after `done`.
- For N = 0: `done` pulses at T0+2. `tx` never leaves 1.
- `done` and `busy` are never high in the same cycle.

## Configuration
- `UART_SHOW_CRLF_EN` defined:
  - After the last string byte, the block sends 0x0D then 0x0A as two additional full frames.
  - `done` is asserted only after the LF frame's NEXT cycle.
  - The trailer is also sent when N = 0. Total bytes = N+2.
- Undefined: no trailer. Transfer length = N bytes exactly.

## Test plan
- Reset with `CLKS_PER_BIT`=4, `start`=0 for 20 cycles → `tx`=1, `busy`=0, `done`=0 throughout.
- `tx_show` = 0x41 ("A") in the MSB byte, `show_len`=1, `start` pulse → `tx` shows 0,1,0,0,0,0,0,1,0,1 (each bit 4 cycles), and `done` pulses exactly 42 cycles after acceptance (+1 for the registered edge).
- `show_len`=3 with bytes 0x31,0x32,0x33 → three frames in order 0x31,0x32,0x33, and `busy` stays high continuously between frames.
- `show_len`=0 → `done` at T0+2 and no start bit on `tx`. With `UART_SHOW_CRLF_EN`, frames 0x0D,0x0A are sent instead.
- `show_len`=31 → exactly 16 frames sent. A second `start` pulsed mid-transfer, with a different `tx_show`, has no effect on the frames sent.
- `reset` asserted during bit 3 of frame 0 → `tx`=1 and `busy`=0 next cycle, and no `done` pulse. A following `start` transmits the new string from byte 0.

Source files
------------

// File: rtl/uart_show_tx.sv
// rtl/uart_show_tx.sv - 8N1 UART transmitter that drains a 16-byte display string.
// Optional: define UART_SHOW_CRLF_EN to append a CR LF trailer to every transfer.
module uart_show_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] tx_show,
    input  logic [4:0]   show_len,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         tx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic [2:0]    state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [127:0]  shbuf;
    logic [4:0]    remaining;
    logic          fin;

    logic          baud_end;
    logic [4:0]    len_clamped;
    logic [4:0]    rem_dec;
    logic [7:0]    cur_byte;
    logic [127:0]  next_buf;
    logic [127:0]  load_buf;
    logic [4:0]    load_rem;
    logic [2:0]    load_state;

    assign baud_end    = (baud == BAUD_LAST);
    assign len_clamped = (show_len > 5'd16) ? 5'd16 : show_len;
    assign rem_dec     = (remaining == 5'd0) ? 5'd0 : remaining - 5'd1;
    assign cur_byte    = shbuf[127:120];

    always_comb begin
        next_buf = {shbuf[119:0], 8'h00};
`ifdef UART_SHOW_CRLF_EN
        // The trailer is injected into the vacated top byte once the string runs out.
        if (rem_dec == 5'd2) begin
            next_buf[127:120] = 8'h0D;
        end else if (rem_dec == 5'd1) begin
            next_buf[127:120] = 8'h0A;
        end
`endif
    end

    always_comb begin
`ifdef UART_SHOW_CRLF_EN
        load_buf   = (len_clamped == 5'd0) ? {8'h0D, 120'd0} : tx_show;
        load_rem   = len_clamped + 5'd2;
        load_state = S_START;
`else
        load_buf   = tx_show;
        load_rem   = len_clamped;
        load_state = (len_clamped == 5'd0) ? S_NEXT : S_START;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            baud      <= '0;
            bit_idx   <= 3'd0;
            shbuf     <= '0;
            remaining <= 5'd0;
            fin       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx        <= 1'b1;
        end else begin
            // Outputs trail the state by one cycle so tx, busy and done stay aligned.
            fin  <= 1'b0;
            done <= fin;
            busy <= (state != S_IDLE);
            case (state)
                S_START: tx <= 1'b0;
                S_DATA:  tx <= cur_byte[bit_idx];
                default: tx <= 1'b1;
            endcase

            case (state)
                S_IDLE: begin
                    baud    <= '0;
                    bit_idx <= 3'd0;
                    if (start) begin
                        shbuf     <= load_buf;
                        remaining <= load_rem;
                        state     <= load_state;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            state   <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= S_NEXT;
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                S_NEXT: begin
                    baud      <= '0;
                    remaining <= rem_dec;
                    shbuf     <= next_buf;
                    if (remaining > 5'd1) begin
                        state <= S_START;
                    end else begin
                        state <= S_IDLE;
                        fin   <= 1'b1;
                    end
                end
                default: begin
                    baud  <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
